// File: rtl/ad7606_pkg.sv
// Shared constants, FSM encoding and frame packing for the AD7606 serial emulator.
package ad7606_pkg;
  localparam int DW         = 16;
  localparam int NCH_LINE   = 4;
  localparam int NLINE      = 2;
  localparam int NCH        = NLINE * NCH_LINE;
  localparam int FRAME_BITS = DW * NCH_LINE;
  localparam int PTR_W      = 7;

  localparam logic [2:0] ST_IDLE  = 3'b001;
  localparam logic [2:0] ST_DELAY = 3'b010;
  localparam logic [2:0] ST_BUSY  = 3'b100;

  typedef logic [NLINE-1:0][FRAME_BITS-1:0] frame_t;

  // Line l carries channels l*NCH_LINE.. in order, lowest channel in the MSBs.
  function automatic frame_t frame_of(input logic [NCH*DW-1:0] hold);
    frame_t f;
    f = '0;
    for (int l = 0; l < NLINE; l++)
      for (int c = 0; c < NCH_LINE; c++)
        f[l][(NCH_LINE-1-c)*DW +: DW] = hold[(l*NCH_LINE+c)*DW +: DW];
    return f;
  endfunction
endpackage

// File: rtl/ad7606_emu_shifter.sv
// Serial frame shifter: bit pointer, per-line shift data and registered dout/frstdata.
module ad7606_emu_shifter
  import ad7606_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  frame_t           load_data,
  input  logic             idle,
  input  logic             cs_fall,
  input  logic             rd_fall,
  input  logic             ad_cs,
  output logic [NLINE-1:0] dout,
  output logic             frstdata
);
  localparam int              PW      = $clog2(FRAME_BITS);
  localparam logic [PTR_W-1:0] PTR_END = PTR_W'(FRAME_BITS);
  localparam logic [PW-1:0]    MSB_IDX = PW'(FRAME_BITS - 1);

  frame_t           shift;
  logic [PTR_W-1:0] bit_ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [NLINE-1:0] bit_cur;
  logic [NLINE-1:0] bit_nxt;

  // Pointer saturates at PTR_END; an exhausted frame reads as zeros.
  assign ptr_nxt = (bit_ptr == PTR_END) ? PTR_END : bit_ptr + PTR_W'(1);

  for (genvar l = 0; l < NLINE; l++) begin : g_line
    assign bit_cur[l] = (bit_ptr != PTR_END) && shift[l][MSB_IDX - bit_ptr[PW-1:0]];
    assign bit_nxt[l] = (ptr_nxt != PTR_END) && shift[l][MSB_IDX - ptr_nxt[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      shift    <= '0;
      bit_ptr  <= PTR_END;
      dout     <= '0;
      frstdata <= 1'b0;
    end else if (load) begin
      shift    <= load_data;
      bit_ptr  <= '0;
      dout     <= '0;
      frstdata <= 1'b0;
    end else if (!idle || ad_cs) begin
      dout     <= '0;
      frstdata <= 1'b0;
    end else if (cs_fall) begin
      dout     <= bit_cur;
      frstdata <= (bit_ptr == '0);
    end else if (rd_fall) begin
      bit_ptr  <= ptr_nxt;
      dout     <= bit_nxt;
      frstdata <= 1'b0;
    end
  end
endmodule

// File: rtl/ad7606_serial_emu.sv
// AD7606 ADC-side emulator: CONVST edge detect, DELAY/BUSY conversion FSM, serial readout.
module ad7606_serial_emu
  import ad7606_pkg::*;
#(
  parameter int BUSY_DELAY  = 2,
  parameter int BUSY_CYCLES = 200
) (
  input  logic              clk,
  input  logic              res,
  input  logic              ad_convstab,
  input  logic              ad_cs,
  input  logic              ad_rd,
  input  logic [NCH*DW-1:0] ch_data,
  output logic              ad_busy,
  output logic              dout_a,
  output logic              dout_b,
  output logic              frstdata,
  output logic              conv_done,
  output logic              conv_ignored
);
  localparam int TMAX = (BUSY_DELAY > BUSY_CYCLES) ? BUSY_DELAY : BUSY_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_DELAY = TW'(BUSY_DELAY - 1);
  localparam logic [TW-1:0] T_BUSY  = TW'(BUSY_CYCLES - 1);

  logic              cv_q, cs_q, rd_q;
  logic              conv_rise, cs_fall, rd_fall;
  logic [2:0]        state;
  logic [TW-1:0]     timer;
  logic [NCH*DW-1:0] hold_reg;
  logic              load;
  logic [NLINE-1:0]  dout;

  assign conv_rise = ~cv_q & ad_convstab;
  assign cs_fall   = cs_q & ~ad_cs;
  assign rd_fall   = rd_q & ~ad_rd;
  assign load      = (state == ST_BUSY) && (timer == '0);

  always_ff @(posedge clk) begin
    if (!res) begin
      cv_q         <= 1'b1;
      cs_q         <= 1'b1;
      rd_q         <= 1'b1;
      state        <= ST_IDLE;
      timer        <= '0;
      hold_reg     <= '0;
      ad_busy      <= 1'b0;
      conv_done    <= 1'b0;
      conv_ignored <= 1'b0;
    end else begin
      cv_q         <= ad_convstab;
      cs_q         <= ad_cs;
      rd_q         <= ad_rd;
      conv_done    <= 1'b0;
      conv_ignored <= 1'b0;
      case (state)
        ST_IDLE: if (conv_rise) begin
          hold_reg <= ch_data;
          timer    <= T_DELAY;
          state    <= ST_DELAY;
        end
        ST_DELAY: begin
          conv_ignored <= conv_rise;
          if (timer == '0) begin
            ad_busy <= 1'b1;
            timer   <= T_BUSY;
            state   <= ST_BUSY;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_BUSY: begin
          conv_ignored <= conv_rise;
          if (timer == '0) begin
            ad_busy   <= 1'b0;
            conv_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ad7606_emu_shifter u_shift (
    .clk       (clk),
    .res       (res),
    .load      (load),
    .load_data (frame_of(hold_reg)),
    .idle      (state == ST_IDLE),
    .cs_fall   (cs_fall),
    .rd_fall   (rd_fall),
    .ad_cs     (ad_cs),
    .dout      (dout),
    .frstdata  (frstdata)
  );

  assign dout_a = dout[0];
  assign dout_b = dout[1];
endmodule

// File: tb/tb_ad7606_serial_emu.sv
// Bench for ad7606_serial_emu: table vectors, randomized frames vs a bit-level model, corner sequences.
module tb_ad7606_serial_emu;
  localparam int BUSY_DELAY  = 2;
  localparam int BUSY_CYCLES = 200;

  logic         clk = 1'b0;
  logic         res, ad_convstab, ad_cs, ad_rd;
  logic [127:0] ch_data;
  logic         ad_busy, dout_a, dout_b, frstdata, conv_done, conv_ignored;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (conv_done) done_cnt++;

  ad7606_serial_emu #(.BUSY_DELAY(BUSY_DELAY), .BUSY_CYCLES(BUSY_CYCLES)) dut (
    .clk(clk), .res(res), .ad_convstab(ad_convstab), .ad_cs(ad_cs), .ad_rd(ad_rd),
    .ch_data(ch_data), .ad_busy(ad_busy), .dout_a(dout_a), .dout_b(dout_b),
    .frstdata(frstdata), .conv_done(conv_done), .conv_ignored(conv_ignored)
  );

  typedef struct {
    logic [127:0] ch;
    logic [63:0]  ea;
    logic [63:0]  eb;
  } vec_t;
  vec_t vecs[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: bit j of a line is channel (line*4 + j/16), bit 15 - j%16.
  function automatic logic [63:0] exp_line(input logic [127:0] ch, input int line);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < 64; j++)
      w[63-j] = ch[(line*4 + j/16)*16 + 15 - (j%16)];
    return w;
  endfunction

  task automatic rd_pulse();
    ad_rd = 1'b0;
    repeat (4) tick();
    ad_rd = 1'b1;
    repeat (4) tick();
  endtask

  task automatic convert(input logic [127:0] ch, input bit ig, input string nm);
    int n, m;
    ch_data = ch;
    ad_convstab = 1'b0;
    repeat (5) tick();
    ad_convstab = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ad_busy && n < 20);
    chk({nm, "_busy_lat"}, 64'(n), 64'(BUSY_DELAY + 1));
    m = 0;
    while (ad_busy && m < 1000) begin
      m++;
      if (ig && m == 48) ad_convstab = 1'b0;
      if (ig && m == 50) begin ad_convstab = 1'b1; ch_data = ~ch; end
      tick();
      if (ig && m == 50) chk({nm, "_ignored"}, 64'(conv_ignored), 64'd1);
    end
    chk({nm, "_busy_len"}, 64'(m), 64'(BUSY_CYCLES));
    chk({nm, "_done"}, 64'(conv_done), 64'd1);
    tick();
    chk({nm, "_done_pulse"}, 64'(conv_done), 64'd0);
    ad_convstab = 1'b0;
  endtask

  task automatic read_check(input logic [63:0] ea, input logic [63:0] eb, input int brk,
                            input bit efrst, input string nm);
    logic [63:0] ga, gb;
    int fbad;
    ga = '0; gb = '0; fbad = 0;
    ad_cs = 1'b0;
    tick(); tick();
    for (int j = 0; j < 64; j++) begin
      if (j == brk) begin
        ad_cs = 1'b1;
        tick(); tick();
        chk({nm, "_cs_high"}, 64'({dout_a, dout_b, frstdata}), 64'd0);
        ad_cs = 1'b0;
        tick(); tick();
      end
      ga[63-j] = dout_a;
      gb[63-j] = dout_b;
      if (frstdata !== (efrst && j == 0)) fbad++;
      rd_pulse();
    end
    chk({nm, "_dout_a"}, ga, ea);
    chk({nm, "_dout_b"}, gb, eb);
    chk({nm, "_frstdata"}, 64'(fbad), 64'd0);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_exhaust"}, 64'({dout_a, dout_b}), 64'd0);
      rd_pulse();
    end
    chk({nm, "_exhaust_end"}, 64'({dout_a, dout_b, frstdata}), 64'd0);
    ad_cs = 1'b1;
    tick(); tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rch;
    int d0;
    vecs[0] = '{128'h8888_7777_6666_5555_4444_3333_2222_1111,
                64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    vecs[1] = '{128'hABCD_1234_5A5A_A5A5_0000_FFFF_8000_0001,
                64'h0001_8000_FFFF_0000, 64'hA5A5_5A5A_1234_ABCD};

    res = 1'b0; ad_convstab = 1'b0; ad_cs = 1'b1; ad_rd = 1'b1; ch_data = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(ad_busy), 64'd0);
    chk("rst_dout_a", 64'(dout_a), 64'd0);
    chk("rst_dout_b", 64'(dout_b), 64'd0);
    chk("rst_frstdata", 64'(frstdata), 64'd0);
    chk("rst_done", 64'(conv_done), 64'd0);
    chk("rst_ignored", 64'(conv_ignored), 64'd0);
    res = 1'b1;
    tick();

    for (int i = 0; i < 2; i++) begin
      convert(vecs[i].ch, 1'b0, $sformatf("vec%0d", i));
      read_check(vecs[i].ea, vecs[i].eb, -1, 1'b1, $sformatf("vec%0d", i));
    end

    // Ignored CONVST mid-BUSY plus a CS break after 16 bits.
    convert(vecs[0].ch, 1'b1, "ign");
    read_check(vecs[0].ea, vecs[0].eb, 16, 1'b1, "ign");

    for (int i = 0; i < 3; i++) begin
      rch = {$urandom, $urandom, $urandom, $urandom};
      convert(rch, 1'b0, $sformatf("rnd%0d", i));
      read_check(exp_line(rch, 0), exp_line(rch, 1), int'($urandom_range(1, 63)), 1'b1,
                 $sformatf("rnd%0d", i));
    end

    // Reset 100 clk into BUSY.
    ch_data = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    ad_convstab = 1'b0;
    repeat (5) tick();
    ad_convstab = 1'b1;
    d0 = 0;
    while (!ad_busy && d0 < 20) begin tick(); d0++; end
    chk("mid_rst_busy_seen", 64'(ad_busy), 64'd1);
    repeat (100) tick();
    res = 1'b0;
    tick();
    chk("mid_rst_busy", 64'(ad_busy), 64'd0);
    chk("mid_rst_dout", 64'({dout_a, dout_b}), 64'd0);
    res = 1'b1;
    ad_convstab = 1'b0;
    d0 = done_cnt;
    repeat (250) tick();
    chk("mid_rst_no_done", 64'(done_cnt), 64'(d0));
    chk("mid_rst_idle_busy", 64'(ad_busy), 64'd0);
    read_check(64'd0, 64'd0, -1, 1'b0, "mid_rst");

    convert(vecs[1].ch, 1'b0, "post_rst");
    read_check(vecs[1].ea, vecs[1].eb, -1, 1'b1, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ad7606_serial_emu.md
Name: ad7606_serial_emu

Overview:
- Emulates the ADC side of the AD7606 serial readout interface, responding to an AD7606 read controller in the same clock domain.
- Behaviour: conversion start on a CONVST pulse, a BUSY window, then two serial data lines carrying eight 16-bit samples.
- Uses: FPGA loopback self-test and bench model for controller verification.
- Sample values come from an internal pattern source or bench via a parallel bus captured at conversion start.

Parameters:
BUSY_DELAY, 2, clk cycles from detected CONVST rising edge to ad_busy high (t1)
BUSY_CYCLES, 200, clk cycles ad_busy stays high (conversion time)
DW, 16, bits per channel sample
NCH_LINE, 4, channels shifted per DOUT line per frame

Ports:
clk  in  1  system clock
res  in  1  reset; synchronous, active-low
ad_convstab  in  1  conversion start from controller; rising edge starts conversion
ad_cs  in  1  chip select, active low
ad_rd  in  1  serial clock from controller; falling edge advances data
ch_data  in  128  {V8..V1}, V1 in [15:0]; captured at conversion start
ad_busy  out  1  high while converting
dout_a  out  1  serial data, channels V1..V4
dout_b  out  1  serial data, channels V5..V8
frstdata  out  1  high while V1 MSB is presented on dout_a
conv_done  out  1  one-cycle pulse when a conversion completes
conv_ignored  out  1  one-cycle pulse when a CONVST edge arrives during DELAY/BUSY

Behaviour:
- Input registers: cv_q, cs_q, rd_q hold the previous-cycle values of ad_convstab, ad_cs, ad_rd; reset to 1.
  - conv_rise = ~cv_q & ad_convstab
  - cs_fall = cs_q & ~ad_cs
  - rd_fall = rd_q & ~ad_rd
  - No synchronisers: inputs are same-clock registered signals.
- Reset (res low at a clk edge): all outputs 0, FSM to IDLE, counters 0, bit_ptr=64, hold/shift registers 0. Applies mid-conversion or mid-read.
- Conversion FSM:
  - IDLE: on conv_rise, capture ch_data into hold_reg, load timer, go to DELAY.
  - DELAY: count BUSY_DELAY cycles, then set ad_busy=1 and go to BUSY.
  - BUSY: count BUSY_CYCLES. On the final cycle:
    - ad_busy<=0 and conv_done<=1 for one cycle.
    - Load shift_a={V1,V2,V3,V4} and shift_b={V5,V6,V7,V8}, V1 MSB first.
    - bit_ptr<=0; return to IDLE.
  - conv_rise while in DELAY or BUSY: ignored, conv_ignored pulses, timer unaffected.
- Latency: ad_busy rises BUSY_DELAY+1 clk after the ad_convstab rising edge at the input, and stays high exactly BUSY_CYCLES cycles.
- Readout (active whenever FSM is in IDLE; shift registers frozen during DELAY/BUSY):
  - cs_fall: dout_a/dout_b <= bit (63-bit_ptr) of shift_a/shift_b, so MSB of V1/V5 at bit_ptr=0. frstdata<=1 if bit_ptr==0.
  - rd_fall with ad_cs low and no cs_fall in the same cycle: bit_ptr<=bit_ptr+1 and present the next bit; frstdata<=0.
  - cs_fall and rd_fall in the same cycle: treated as cs_fall only.
  - ad_cs high: dout_a/dout_b<=0 and frstdata<=0; bit_ptr is held, so per-channel CS framing continues the stream.
  - bit_ptr reaching 64 (exhausted): dout lines driven 0; bit_ptr saturates at 64 until the next conv_done.
  - Reads during DELAY/BUSY: dout lines 0, bit_ptr unchanged.
- A conversion completing while CS is low replaces the shift data and resets bit_ptr=0; the next rd_fall presents bit 62.
- Outputs are registered; dout changes in the clk edge where rd_fall is detected, i.e. one clk after ad_rd falls.
- No arithmetic beyond counters:
  - timer width = clog2(max(BUSY_DELAY, BUSY_CYCLES)+1)
  - bit_ptr width 7

Decomposition:
- Shared package ad7606_pkg:
  - FSM state encoding (IDLE/DELAY/BUSY, one-hot, matching the controller's style)
  - DW, NCH_LINE
  - FRAME_BITS = DW*NCH_LINE = 64
- One natural sub-module, ad7606_emu_shifter: owns bit_ptr, shift_a/shift_b and the dout/frstdata logic. Its inputs are load, cs_fall, rd_fall and ad_cs.
- The top holds the edge detectors and the conversion FSM.

Test Plan:
- Reset then ch_data V1..V8=16'h1111..16'h8888; ad_convstab low 5 clk then high -> ad_busy high at clk 3 after the rising edge, low after 200 clk, conv_done one pulse.
- After conversion, CS low then 64 RD pulses (4 clk low/4 high) -> dout_a bits at each rd_fall reconstruct 1111,2222,3333,4444 and dout_b reconstruct 5555..8888; frstdata high only before the first rd_fall.
- A 65th and 66th RD pulse -> dout_a=dout_b=0, bit_ptr stays 64.
- Second ad_convstab rising edge 50 clk into BUSY -> conv_ignored pulse, ad_busy still falls at the original cycle, data from the first capture.
- CS high after 16 bits, low again -> stream resumes with MSB of V2=2222 on dout_a; dout 0 while CS high.
- res low at clk 100 of BUSY -> next clk ad_busy=0, dout 0, FSM IDLE; a subsequent read returns all zeros.
